// File: rtl/iq_packer_pkg.sv
// iq_pkg: shared types, constants and helpers for the receive-side IQ packer.
//   state_e   - packer FSM states (IDLE, RUN, DRAIN)
//   WORD_W    - width of a packed output word
//   FRAME_LOG2- default log2 of words per frame (one 16-beat burst)
//   IQ_HALF_W - width of each half of a packed word
//   pack_iq   - sign-extends an I/Q pair of width iw and packs it {I, Q}
package iq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int WORD_W     = 32;
  localparam int FRAME_LOG2 = 4;
  localparam int IQ_HALF_W  = 16;

  // Inputs arrive zero-padded to IQ_HALF_W; bits at or above iw are replaced
  // by bit iw-1, so iw == IQ_HALF_W passes the samples through unchanged.
  function automatic logic [WORD_W-1:0] pack_iq(
    input logic [IQ_HALF_W-1:0] i,
    input logic [IQ_HALF_W-1:0] q,
    input int                   iw
  );
    logic [IQ_HALF_W-1:0] si;
    logic [IQ_HALF_W-1:0] sq;
    logic [3:0]           msb;
    msb = 4'(iw - 1);
    for (int b = 0; b < IQ_HALF_W; b++) begin
      si[b] = (b < iw) ? i[b] : i[msb];
      sq[b] = (b < iw) ? q[b] : q[msb];
    end
    return {si, sq};
  endfunction

endpackage

// File: rtl/iq_packer_if.sv
// iq_packer_if: sample-in / word-out bundle of the IQ packer.
//   rx_valid, rx_i, rx_q - input pair strobe and two's complement samples
//   Sin, Ien, sync       - packed word, word valid, frame-start marker
// master: the side feeding samples and observing words (front-end / bench)
// slave : the packer itself
interface iq_packer_if
  import iq_pkg::*;
#(
  parameter int IW = 12
);
  logic              rx_valid;
  logic [IW-1:0]     rx_i;
  logic [IW-1:0]     rx_q;
  logic [WORD_W-1:0] Sin;
  logic              Ien;
  logic              sync;

  modport master (output rx_valid, rx_i, rx_q, input Sin, Ien, sync);
  modport slave  (input rx_valid, rx_i, rx_q, output Sin, Ien, sync);
endinterface

// File: rtl/iq_packer_decim.sv
// iq_decim: power-of-two decimator for the IQ packer.
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   start_i       - run start; latches dec_i and clears the phase counter
//   dec_i         - decimation exponent, keep 1 of every 2^dec pairs
//   valid_i       - pair accepted this cycle
//   keep_o        - accepted pair is the one to keep (phase counter at 0)
module iq_decim (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] dec_i,
  input  logic       valid_i,
  output logic       keep_o
);

  logic [2:0] decR_q, decR_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [7:0] dcntMax;

  assign dcntMax = (8'd1 << decR_q) - 8'd1;
  assign keep_o  = valid_i && (dcnt_q == 8'd0);

  // The exponent is only sampled at start, so dec changes mid-run are ignored.
  always_comb begin
    decR_d = decR_q;
    dcnt_d = dcnt_q;
    if (start_i) begin
      decR_d = dec_i;
      dcnt_d = 8'd0;
    end else if (valid_i) begin
      dcnt_d = (dcnt_q == dcntMax) ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      decR_q <= 3'd0;
      dcnt_q <= 8'd0;
    end else begin
      decR_q <= decR_d;
      dcnt_q <= dcnt_d;
    end
  end

endmodule

// File: rtl/iq_packer.sv
// iq_packer: packs decimated 12-bit I/Q pairs into 32-bit words grouped in
// fixed frames, padding a stopped frame with zero words.
//   Sclk, rst_n - sample clock, asynchronous active-low reset
//   en          - run request (level)
//   dec         - decimation exponent, latched when a run starts
//   bus         - sample input and packed word output (slave side)
//   busy        - packer is not idle
//   frame_cnt   - completed frames since reset, wrapping
module iq_packer
  import iq_pkg::*;
#(
  parameter int IW         = 12,
  parameter int FRAME_LOG2 = iq_pkg::FRAME_LOG2
) (
  input  logic               Sclk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [2:0]         dec,
  iq_packer_if.slave         bus,
  output logic               busy,
  output logic [WORD_W-1:0]  frame_cnt
);

  state_e                  state_q, state_d;
  logic [FRAME_LOG2-1:0]   wcnt_q, wcnt_d;
  logic [WORD_W-1:0]       sin_q, sin_d;
  logic                    ien_q, ien_d;
  logic                    sync_q, sync_d;
  logic                    busy_q, busy_d;
  logic [WORD_W-1:0]       frameCnt_q, frameCnt_d;

  logic                    start;
  logic                    accept;
  logic                    keep;
  logic                    wcntLast;
  logic [IQ_HALF_W-1:0]    iExt;
  logic [IQ_HALF_W-1:0]    qExt;

  // A pair arriving in the cycle en drops is never accepted, so the frame
  // position seen when deciding IDLE vs DRAIN is final.
  assign start    = (state_q == IDLE) && en;
  assign accept   = (state_q == RUN) && en && bus.rx_valid;
  assign wcntLast = &wcnt_q;

  always_comb begin
    iExt         = '0;
    qExt         = '0;
    iExt[IW-1:0] = bus.rx_i;
    qExt[IW-1:0] = bus.rx_q;
  end

  iq_decim u_decim (
    .clk_i   (Sclk),
    .rst_ni  (rst_n),
    .start_i (start),
    .dec_i   (dec),
    .valid_i (accept),
    .keep_o  (keep)
  );

  // Sin keeps its last value when no word is emitted; Ien/sync are pulses.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    sin_d      = sin_q;
    ien_d      = 1'b0;
    sync_d     = 1'b0;
    frameCnt_d = frameCnt_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          wcnt_d  = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = (wcnt_q == '0) ? IDLE : DRAIN;
        end else if (keep) begin
          sin_d  = pack_iq(iExt, qExt, IW);
          ien_d  = 1'b1;
          sync_d = (wcnt_q == '0);
          wcnt_d = wcnt_q + 1'b1;
          if (wcntLast) frameCnt_d = frameCnt_q + 32'd1;
        end
      end
      DRAIN: begin
        sin_d  = '0;
        ien_d  = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        if (wcntLast) begin
          frameCnt_d = frameCnt_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      sin_q      <= '0;
      ien_q      <= 1'b0;
      sync_q     <= 1'b0;
      busy_q     <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      sin_q      <= sin_d;
      ien_q      <= ien_d;
      sync_q     <= sync_d;
      busy_q     <= busy_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  assign bus.Sin   = sin_q;
  assign bus.Ien   = ien_q;
  assign bus.sync  = sync_q;
  assign busy      = busy_q;
  assign frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_iq_packer.sv
// tb_iq_packer: self-checking bench for iq_packer. Expected words are pushed
// to a scoreboard queue as stimulus is driven and compared when Ien appears.
module tb_iq_packer;
  import iq_pkg::*;

  typedef struct {
    logic [11:0] i;
    logic [11:0] q;
    logic [31:0] sinExp;
  } vec_t;

  typedef struct {
    logic [31:0] sin;
    logic        sync;
  } word_t;

  logic        Sclk;
  logic        rst_n;
  logic        en;
  logic [2:0]  dec;
  logic        busy;
  logic [31:0] frame_cnt;

  int    checks   = 0;
  int    failures = 0;
  word_t expQ[$];
  word_t gotExp;
  vec_t  vecTable[16];
  int    expFrames;

  iq_packer_if #(.IW(12)) bus ();

  iq_packer #(.IW(12), .FRAME_LOG2(4)) dut (
    .Sclk      (Sclk),
    .rst_n     (rst_n),
    .en        (en),
    .dec       (dec),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  // Scoreboard: every emitted word must match the oldest expected entry.
  always @(negedge Sclk) begin
    if (rst_n) begin
      checks++;
      if (bus.sync && !bus.Ien) begin
        failures++;
        $display("[TB] FAIL syncWithoutIen sync=%b Ien=%b required sync=0", bus.sync, bus.Ien);
      end
      if (bus.Ien) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpectedWord got Sin=%h sync=%b, required no word", bus.Sin, bus.sync);
        end else begin
          gotExp = expQ.pop_front();
          checks++;
          if (bus.Sin !== gotExp.sin) begin
            failures++;
            $display("[TB] FAIL wordSin got %h required %h", bus.Sin, gotExp.sin);
          end
          checks++;
          if (bus.sync !== gotExp.sync) begin
            failures++;
            $display("[TB] FAIL wordSync got %b required %b (Sin=%h)", bus.sync, gotExp.sync, bus.Sin);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [11:0] i, input logic [11:0] q);
    bus.rx_valid = v;
    bus.rx_i     = i;
    bus.rx_q     = q;
    tick();
  endtask

  task automatic expectWord(input logic [31:0] s, input logic y);
    expQ.push_back('{sin: s, sync: y});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got %h required %h", name, actual, expected);
    end
  endtask

  task automatic drainQueue(input string name, input int maxCycles);
    for (int c = 0; c < maxCycles && expQ.size() > 0; c++) tick();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s pendingWords got %0d required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    vecTable[0]  = '{12'h000, 12'h000, 32'h0000_0000};
    vecTable[1]  = '{12'hFFF, 12'h001, 32'hFFFF_0001};
    vecTable[2]  = '{12'h800, 12'h7FF, 32'hF800_07FF};
    vecTable[3]  = '{12'h7FF, 12'h800, 32'h07FF_F800};
    vecTable[4]  = '{12'h001, 12'hFFF, 32'h0001_FFFF};
    vecTable[5]  = '{12'h123, 12'h456, 32'h0123_0456};
    vecTable[6]  = '{12'h9AB, 12'hCDE, 32'hF9AB_FCDE};
    vecTable[7]  = '{12'h400, 12'hC00, 32'h0400_FC00};
    vecTable[8]  = '{12'h3FF, 12'hBFF, 32'h03FF_FBFF};
    vecTable[9]  = '{12'hA5A, 12'h5A5, 32'hFA5A_05A5};
    vecTable[10] = '{12'h0FF, 12'hF00, 32'h00FF_FF00};
    vecTable[11] = '{12'h555, 12'hAAA, 32'h0555_FAAA};
    vecTable[12] = '{12'h801, 12'h001, 32'hF801_0001};
    vecTable[13] = '{12'h7FE, 12'hFFE, 32'h07FE_FFFE};
    vecTable[14] = '{12'hC34, 12'h34C, 32'hFC34_034C};
    vecTable[15] = '{12'hFFF, 12'hFFF, 32'hFFFF_FFFF};

    rst_n        = 1'b0;
    en           = 1'b0;
    dec          = 3'd0;
    bus.rx_valid = 1'b0;
    bus.rx_i     = '0;
    bus.rx_q     = '0;
    expFrames    = 0;

    #5;
    checkOutput("resetSin", bus.Sin, 32'h0);
    checkOutput("resetIen", 32'(bus.Ien), 32'h0);
    checkOutput("resetSync", 32'(bus.sync), 32'h0);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetFrameCnt", frame_cnt, 32'h0);
    @(negedge Sclk);
    #2 rst_n = 1'b1;
    tick();

    // Valids while idle must produce nothing.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 12'h111, 12'h222);
    bus.rx_valid = 1'b0;
    tick();
    checkOutput("idleBusy", 32'(busy), 32'h0);

    // Basic pack followed by a table-driven frame of sign-extension cases.
    en = 1'b1;
    tick();
    checkOutput("runBusy", 32'(busy), 32'h1);
    for (int k = 0; k < 16; k++) begin
      expectWord(32'h07FF_F800, k == 0);
      applyStimulus(1'b1, 12'h7FF, 12'h800);
    end
    expFrames++;
    checkOutput("basicFrameCnt", frame_cnt, 32'(expFrames));
    for (int k = 0; k < 16; k++) begin
      expectWord(vecTable[k].sinExp, k == 0);
      applyStimulus(1'b1, vecTable[k].i, vecTable[k].q);
    end
    expFrames++;
    // Aligned stop: no padding, immediate idle.
    bus.rx_valid = 1'b1;
    en           = 1'b0;
    tick();
    bus.rx_valid = 1'b0;
    drainQueue("tableFrame", 4);
    checkOutput("alignedBusy", 32'(busy), 32'h0);
    tick();
    tick();
    checkOutput("alignedFrameCnt", frame_cnt, 32'(expFrames));

    // Decimation by 4.
    dec = 3'd2;
    en  = 1'b1;
    tick();
    dec = 3'd0;
    for (int idx = 0; idx < 64; idx++) begin
      if (idx % 4 == 0) expectWord({16'(idx), 16'h0000}, idx == 0);
      applyStimulus(1'b1, 12'(idx), 12'h000);
    end
    bus.rx_valid = 1'b0;
    en           = 1'b0;
    tick();
    drainQueue("decimFrame", 4);
    expFrames++;
    checkOutput("decimFrameCnt", frame_cnt, 32'(expFrames));
    checkOutput("decimBusy", 32'(busy), 32'h0);

    // Drain after 5 words: 11 back-to-back zero words, valids ignored.
    en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      expectWord({16'(k + 1), 16'hFF00 + 16'(k)}, k == 0);
      applyStimulus(1'b1, 12'(k + 1), 12'hF00 + 12'(k));
    end
    en = 1'b0;
    for (int k = 0; k < 11; k++) expectWord(32'h0, 1'b0);
    applyStimulus(1'b1, 12'h123, 12'h456);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b1, 12'(k + 40), 12'h7A5);
      checkOutput("drainIen", 32'(bus.Ien), 32'h1);
    end
    expFrames++;
    checkOutput("drainBusyFall", 32'(busy), 32'h0);
    applyStimulus(1'b0, 12'h000, 12'h000);
    checkOutput("drainIenAfter", 32'(bus.Ien), 32'h0);
    drainQueue("drainFrame", 2);
    checkOutput("drainFrameCnt", frame_cnt, 32'(expFrames));

    // Rate change mid-run has no effect; en during DRAIN waits for IDLE.
    dec = 3'd0;
    en  = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == 2) dec = 3'd3;
      expectWord({16'(k), 16'(k)}, k == 0);
      applyStimulus(1'b1, 12'(k), 12'(k));
    end
    en = 1'b0;
    for (int k = 0; k < 8; k++) expectWord(32'h0, 1'b0);
    applyStimulus(1'b0, 12'h000, 12'h000);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) en = 1'b1;
      tick();
    end
    expFrames++;
    checkOutput("rearmIdleGap", 32'(busy), 32'h0);
    tick();
    checkOutput("rearmBusy", 32'(busy), 32'h1);
    checkOutput("rearmFrameCnt", frame_cnt, 32'(expFrames));
    for (int idx = 0; idx < 16; idx++) begin
      if (idx % 8 == 0) expectWord({16'(idx + 100), 16'hF800}, idx == 0);
      applyStimulus(1'b1, 12'(idx + 100), 12'h800);
    end
    en = 1'b0;
    for (int k = 0; k < 14; k++) expectWord(32'h0, 1'b0);
    applyStimulus(1'b0, 12'h000, 12'h000);
    drainQueue("rearmDrain", 20);
    tick();
    expFrames++;
    checkOutput("rearmEndFrameCnt", frame_cnt, 32'(expFrames));
    checkOutput("rearmEndBusy", 32'(busy), 32'h0);

    // Asynchronous reset mid-frame.
    dec = 3'd0;
    en  = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      expectWord({16'(k + 1), 16'h0000}, k == 0);
      applyStimulus(1'b1, 12'(k + 1), 12'h000);
    end
    bus.rx_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetSin", bus.Sin, 32'h0);
    checkOutput("midResetIen", 32'(bus.Ien), 32'h0);
    checkOutput("midResetBusy", 32'(busy), 32'h0);
    checkOutput("midResetFrameCnt", frame_cnt, 32'h0);
    checkOutput("midResetPending", 32'(expQ.size()), 32'h0);
    expQ.delete();
    @(negedge Sclk);
    #1 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      expectWord({16'(k + 9), 16'h0001}, k == 0);
      applyStimulus(1'b1, 12'(k + 9), 12'h001);
    end
    en = 1'b0;
    for (int k = 0; k < 13; k++) expectWord(32'h0, 1'b0);
    applyStimulus(1'b0, 12'h000, 12'h000);
    drainQueue("postResetDrain", 20);
    tick();
    checkOutput("postResetFrameCnt", frame_cnt, 32'h1);
    checkOutput("postResetBusy", 32'(busy), 32'h0);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iq_packer.md
# iq_packer

Receive-side sample packer that sits directly upstream of the OCM stream bridge in the Sclk domain. It takes 12-bit I/Q pairs from the RF front-end interface and optionally decimates them by a power of two. It packs each kept pair into one 32-bit word and drives the bridge's `Sin`/`Ien`/`sync` inputs. Words are grouped into fixed frames that match the 16-beat AXI burst. A stop request completes the current frame with zero padding, so the bridge never holds a partial burst.

## Interface
- `IW`, 12, sample width of `rx_i`/`rx_q` (2..16)
- `FRAME_LOG2`, 4, log2 of words per frame (16 = one AXI burst)
- `Sclk` in 1: sample clock; single clock domain
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in 1: run request, level
- `dec` in 3: decimation exponent; keep 1 of every 2^dec valid pairs
- `rx_valid` in 1: input pair strobe
- `rx_i` in IW: I sample, two's complement
- `rx_q` in IW: Q sample, two's complement
- `Sin` out 32: packed word `{sext(I,16), sext(Q,16)}`
- `Ien` out 1: `Sin` valid, one word per asserted cycle
- `sync` out 1: high with `Ien` on word 0 of each frame
- `busy` out 1: state != IDLE
- `frame_cnt` out 32: completed frames since reset, wraps modulo 2^32

## Operation
- States:
  - IDLE: outputs quiet, counters held, `rx_valid` ignored.
  - RUN: accept and pack samples.
  - DRAIN: pad the current frame to its end with zero words.
- IDLE→RUN when `en`=1.
  - `dec` is latched into `dec_r` on this transition.
  - Decimation counter `dcnt` (8 bits) and word counter `wcnt` (FRAME_LOG2 bits) are cleared.
  - `dec` changes while RUN/DRAIN have no effect.
- RUN, per `rx_valid`:
  - The pair is kept iff `dcnt`==0.
  - `dcnt` increments and wraps to 0 after 2^dec_r−1.
  - `dec_r`=0 keeps every pair.
- Kept pair produces the registered outputs:
  - `Sin` ← sign-extended pack; `Ien` ← 1; `sync` ← (`wcnt`==0).
  - `wcnt` increments modulo 2^FRAME_LOG2.
  - `frame_cnt` increments when `wcnt` was 2^FRAME_LOG2−1.
- RUN with `en`=0:
  - If `wcnt`==0, go to IDLE. A pair accepted in that same cycle is dropped.
  - Otherwise go to DRAIN.
- DRAIN:
  - Each cycle emits `Sin`=0, `Ien`=1, `sync`=0, and increments `wcnt`.
  - On the word that wraps `wcnt` to 0: `frame_cnt` increments and the state goes to IDLE.
  - `rx_valid` and `en` are ignored throughout DRAIN.
- `en` reasserted during DRAIN: honoured only after the return to IDLE, one cycle minimum in IDLE.
- `Sin` holds its last value when `Ien`=0. Consumers qualify it with `Ien` only.
- Width rule: IW<16 sign-extends from bit IW−1; IW=16 passes through unchanged.

## Timing
- Reset values: `Sin`=0, `Ien`=0, `sync`=0, `busy`=0, `frame_cnt`=0, state IDLE, `dcnt`=`wcnt`=0. Reset is asynchronous and may occur mid-frame; no padding is emitted afterwards.
- Latency: kept `rx_valid` at cycle n → `Ien`/`Sin`/`sync` at cycle n+1. No backpressure; throughput is one word per cycle.
- `busy` is registered: it rises the cycle after `en` is sampled in IDLE and falls the cycle after the last DRAIN word.
- The first `rx_valid` can be accepted in the cycle after IDLE→RUN.
- DRAIN length is 2^FRAME_LOG2 − `wcnt` cycles, back-to-back `Ien`.
- `sync` never asserts without `Ien`.

## Structure
- Shared package `iq_pkg` holds:
  - state enum `{IDLE, RUN, DRAIN}`;
  - constant `WORD_W`=32, `FRAME_LOG2` default, `IQ_HALF_W`=16;
  - function `pack_iq(i,q)` performing sign-extension and concatenation.
- One sub-module is natural: `iq_decim`, holding the `dcnt`/`dec_r` logic and producing the `keep` strobe.
- FSM, packing register and counters stay in `iq_packer`. Expected 150–250 lines total.

## Test plan
- **Basic pack:** dec=0, en=1, 16 pairs I=0x7FF, Q=0x800. Expect 16 `Ien` pulses, each with `Sin`=0x07FFF800. `sync` is high on the first only, then `frame_cnt`=1.
- **Decimation:** dec=2, 64 consecutive valids with I=index, Q=0. Expect 16 words carrying I=0,4,8,…,60 and `frame_cnt`=1.
- **Drain:** stop after 5 words by dropping `en`. Expect 11 consecutive zero words with `Ien`=1 and `sync`=0, then `busy`=0 and `frame_cnt`=1. Valids during DRAIN produce no data.
- **Aligned stop:** drop `en` exactly when `wcnt`=0 after 32 words. Expect immediate IDLE, no padding, and `frame_cnt`=2.
- **Reset mid-frame:** assert `rst_n`=0 after 7 words. All outputs are 0 asynchronously. After release with `en`=1, the first word carries `sync`=1.
- **Rate change / re-arm:** change `dec` from 0 to 3 while RUN; the rate is unchanged. Stop, re-enable, and confirm 1-in-8 decimation. Assert `en` during DRAIN and confirm the restart happens only after IDLE.
